// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// The optional misalignment check is enabled by defining DMEM_MISALIGN_CHK_EN.
package dmem_pkg;

  localparam int WORD_W  = 32;
  localparam int BYTE_W  = 8;
  localparam int LANES   = WORD_W / BYTE_W;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  localparam logic [LANES-1:0] BE_WORD = 4'b1111;
  localparam logic [LANES-1:0] BE_LO_H = 4'b0011;
  localparam logic [LANES-1:0] BE_HI_H = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // A request is misaligned when its byte offset is non-zero and the access
  // cannot be served inside a single word: any load, a full-word store, or a
  // half-word store that starts on an odd byte.
  function automatic logic misaligned(input logic             we,
                                      input logic [1:0]       lo,
                                      input logic [LANES-1:0] be);
    logic half;
    half = (be == BE_LO_H) || (be == BE_HI_H);
    return (lo != 2'b00) && (!we || (be == BE_WORD) || (half && lo[0]));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data store with per-byte write enables.
// Writes take effect on the rising edge; reads are combinational from the
// current address. Contents have no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [AW-1:0]     a,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[a][i*BYTE_W +: BYTE_W] <= d[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign q = mem[a];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the pipeline data-memory port.
// One request at a time: accept, wait LAT cycles, then present a response
// that is held until the requester takes it. busy feeds the CPU stall.
// Define DMEM_MISALIGN_CHK_EN to flag misaligned requests as errors.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; req_ready high
// WAIT  | request captured; cnt counts down the remaining wait states
// RESP  | response valid and frozen until resp_ready
//
// LAT must lie in 1..LAT_MAX so that LAT-1 fits the 4-bit counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  state_e            state;
  state_e            state_nxt;
  logic [CNT_W-1:0]  cnt;

  logic              cap_we;
  logic [WORD_W-1:0] cap_addr;
  logic [LANES-1:0]  cap_be;
  logic [WORD_W-1:0] cap_wdata;

  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  logic              in_range;
  logic              misal;
  logic              bad;
  logic              commit;
  logic              mem_we;
  logic [WORD_W-1:0] mem_q;

  // Anything above the word index must be zero for the access to hit the array.
  assign in_range = (cap_addr[WORD_W-1:AW+2] == '0);

`ifdef DMEM_MISALIGN_CHK_EN
  assign misal = misaligned(cap_we, cap_addr[1:0], cap_be);
`else
  // Byte offset is irrelevant when the alignment check is compiled out.
  logic unused_addr_lo;
  assign unused_addr_lo = ^cap_addr[1:0];
  assign misal          = 1'b0;
`endif

  assign bad    = !in_range || misal;
  assign commit = (state == WAIT) && (cnt == '0);
  // A store reaches the array only on the WAIT->RESP edge, so a reset
  // during WAIT leaves memory untouched.
  assign mem_we = commit && cap_we && !bad;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk (clk),
    .we  (mem_we),
    .be  (cap_be),
    .a   (cap_addr[AW+1:2]),
    .d   (cap_wdata),
    .q   (mem_q)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture on acceptance and wait-state down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_be    <= req_be;
            cap_wdata <= req_wdata;
            cnt       <= CNT_W'(LAT - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Response registers: loaded when the wait expires, cleared on retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= bad;
      rdata_q <= (cap_we || bad) ? '0 : mem_q;
    end else if ((state == RESP) && resp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic, checked every cycle against a transaction-level model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] mdl_mem [DEPTH];
  bit          open = 1'b0;
  int          edge_n = 0;
  int          acc_e = 0;
  logic [31:0] exp_rdata;
  bit          exp_err;
  bit          pend_store;
  int          pend_idx;
  logic [3:0]  pend_be;
  logic [31:0] pend_wd;

  function automatic bit is_bad(input bit we, input logic [31:0] addr, input logic [3:0] be);
    bit b;
    b = (addr >= 32'(DEPTH * 4));
`ifdef DMEM_MISALIGN_CHK_EN
    if (addr[1:0] != 2'b00 &&
        (!we || be == 4'hF || ((be == 4'h3 || be == 4'hC) && addr[0])))
      b = 1'b1;
`endif
    return b;
  endfunction

  // Accept when idle, commit LAT edges later, retire on the first edge
  // after the response is visible with resp_ready high.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      open = 1'b0;
    end else begin
      edge_n++;
      if (open) begin
        if (edge_n - acc_e == LAT && pend_store) begin
          for (int i = 0; i < 4; i++)
            if (pend_be[i]) mdl_mem[pend_idx][i*8 +: 8] = pend_wd[i*8 +: 8];
        end
        if (edge_n - acc_e > LAT && resp_ready) open = 1'b0;
      end else if (req_valid) begin
        open       = 1'b1;
        acc_e      = edge_n;
        exp_err    = is_bad(req_we, req_addr, req_be);
        pend_idx   = int'(req_addr[7:2]);
        pend_store = req_we && !exp_err;
        pend_be    = req_be;
        pend_wd    = req_wdata;
        exp_rdata  = (req_we || exp_err) ? 32'h0 : mdl_mem[pend_idx];
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit vis;
      vis = open && (edge_n - acc_e >= LAT);
      chk("req_ready",  {31'b0, req_ready},  {31'b0, !open});
      chk("busy",       {31'b0, busy},       {31'b0, open});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, vis});
      chk("resp_rdata", resp_rdata, vis ? exp_rdata : 32'h0);
      chk("resp_err",   {31'b0, resp_err},   {31'b0, vis && exp_err});
    end
  end

  // rr_mode: 0 = resp_ready tied high, 1 = random, 2 = hold low 5 cycles in RESP.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int rr_mode, input bit keep_valid,
                        output int lat, output logic [31:0] rd, output logic er);
    int c;
    bit done;
    bit v_pre;
    lat = -1; rd = '0; er = 1'b0; done = 1'b0; c = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    if (keep_valid) begin
      req_we = 1'b0; req_addr = 32'h10;
    end else begin
      req_valid = 1'b0;
      req_we = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
    end
    while (!done && c < 40) begin
      if (resp_valid && lat < 0) begin
        lat = c; rd = resp_rdata; er = resp_err;
      end
      case (rr_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = (lat >= 0) && (c >= lat + 5);
      endcase
      v_pre = resp_valid;
      @(posedge clk); #1;
      c++;
      if (v_pre && resp_ready) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL txn_timeout: no retire after 40 cycles, retire required");
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && open; i++) begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
    end
    if (open) begin
      n_total++;
      $display("FAIL idle_timeout: still busy after 40 cycles, idle required");
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          sel;
    logic [31:0] a;

    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // Reset held with a pending request: nothing may be accepted.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_busy",       {31'b0, busy},       32'd0);
      chk("rst_rdata",      resp_rdata,          32'd0);
    end
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill the whole array so later loads have known contents.
    for (int i = 0; i < DEPTH; i++)
      do_txn(1'b1, 32'(i * 4), 4'hF, $urandom, 0, 1'b0, lat, rd, er);

    // Full-word store then load.
    do_txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 1'b0, lat, rd, er);
    chk("st_latency", 32'(lat), 32'd2);
    chk("st_rdata", rd, 32'h0);
    do_txn(1'b0, 32'h10, 4'h0, 32'h0, 0, 1'b0, lat, rd, er);
    chk("ld_latency", 32'(lat), 32'd2);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_err", {31'b0, er}, 32'd0);

    // Single-lane store merges into the existing word.
    do_txn(1'b1, 32'h10, 4'h1, 32'h000000AA, 1, 1'b0, lat, rd, er);
    do_txn(1'b0, 32'h10, 4'hF, 32'h0, 1, 1'b0, lat, rd, er);
    chk("lane_rdata", rd, 32'hDEADBEAA);

    // be=0000 store is acknowledged and leaves memory alone.
    do_txn(1'b1, 32'h10, 4'h0, 32'h12121212, 0, 1'b0, lat, rd, er);
    chk("be0_err", {31'b0, er}, 32'd0);
    do_txn(1'b0, 32'h10, 4'h0, 32'h0, 0, 1'b0, lat, rd, er);
    chk("be0_rdata", rd, 32'hDEADBEAA);

    // Back-pressure with a new request waiting.
    do_txn(1'b0, 32'h10, 4'h0, 32'h0, 2, 1'b1, lat, rd, er);
    chk("hold_rdata", rd, 32'hDEADBEAA);
    chk("retire_ready", {31'b0, req_ready}, 32'd1);
    chk("retire_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("after_retire_busy", {31'b0, busy}, 32'd1);
    wait_idle();

    // Out-of-range accesses.
    do_txn(1'b0, 32'h100, 4'hF, 32'h0, 0, 1'b0, lat, rd, er);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_err", {31'b0, er}, 32'd1);
    do_txn(1'b1, 32'h100, 4'hF, 32'h5A5A5A5A, 0, 1'b0, lat, rd, er);
    chk("oor_st_err", {31'b0, er}, 32'd1);
    for (int i = 0; i < DEPTH; i++)
      do_txn(1'b0, 32'(i * 4), 4'hF, 32'h0, 1, 1'b0, lat, rd, er);

    // Reset during WAIT of a store drops it.
    do_txn(1'b1, 32'h20, 4'hF, 32'h12345678, 0, 1'b0, lat, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    do_txn(1'b0, 32'h20, 4'hF, 32'h0, 0, 1'b0, lat, rd, er);
    chk("midrst_rdata", rd, 32'h12345678);
    do_txn(1'b0, 32'h22, 4'hF, 32'h0, 0, 1'b0, lat, rd, er);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("mis_rdata", rd, 32'h0);
    chk("mis_err", {31'b0, er}, 32'd1);
`else
    chk("mis_rdata", rd, 32'h12345678);
    chk("mis_err", {31'b0, er}, 32'd0);
`endif

    // Random traffic.
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      else if (sel < 9) a = 32'h100 + 32'($urandom_range(0, 255));
      else              a = $urandom;
      do_txn(1'($urandom), a, 4'($urandom), $urandom, int'($urandom_range(0, 1)), 1'b0,
             lat, rd, er);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
